// File: rtl/vga_capture_if.sv
// Captured-pixel bus leaving vga_capture: the capture block drives it (master),
// a downstream frame sink reads it (slave).
interface vga_capture_if;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [8:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        frame_start;

    modport master (output pix_valid, pix_x, pix_y, pix_rgb, frame_start);
    modport slave  (input  pix_valid, pix_x, pix_y, pix_rgb, frame_start);
endinterface

// File: rtl/vga_capture.sv
// Recovers line/frame timing from asynchronous VGA syncs, qualifies it, and
// emits active-area pixels with their coordinates once the timing is locked.
module vga_capture #(
    parameter int H_ACTIVE_START = 274,
    parameter int H_DISPLAY      = 1220,
    parameter int V_ACTIVE_START = 35,
    parameter int V_DISPLAY      = 480,
    parameter int H_TOL          = 2,
    parameter int LOCK_LINES     = 4
) (
    input  logic          clk48,
    input  logic          rst,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [1:0]    r_in,
    input  logic [1:0]    g_in,
    input  logic [1:0]    b_in,
    vga_capture_if.master pix,
    output logic          locked,
    output logic [10:0]   line_period,
    output logic [9:0]    frame_lines
);
    localparam logic [10:0] HCNT_MAX  = 11'h7FF;
    localparam logic [9:0]  VLINE_MAX = 10'h3FF;
    localparam logic [11:0] H_LO      = 12'(H_ACTIVE_START);
    localparam logic [11:0] H_HI      = 12'(H_ACTIVE_START + H_DISPLAY);
    localparam logic [10:0] V_LO      = 11'(V_ACTIVE_START);
    localparam logic [10:0] V_HI      = 11'(V_ACTIVE_START + V_DISPLAY);
    localparam logic [10:0] X_OFS     = 11'(H_ACTIVE_START);
    localparam logic [9:0]  Y_OFS     = 10'(V_ACTIVE_START);
    localparam logic [10:0] TOL       = 11'(H_TOL);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);

    typedef enum logic [1:0] {HUNT, HQUAL, VWAIT, LOCKED} state_t;

    // Syncs and colour share one synchronizer so pixels stay aligned with the counters.
    logic [7:0] pad_bus;
    logic [7:0] sync_bus;
    assign pad_bus = {hsync_in, vsync_in, r_in, g_in, b_in};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk48) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pad_bus[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bus[gi] = sync_reg;
        end
    endgenerate

    state_t      state_reg, state_next;
    logic        h_prev_reg, v_prev_reg;
    logic [10:0] hcnt_reg, hcnt_next;
    logic [9:0]  vline_reg, vline_next;
    logic [7:0]  mcnt_reg, mcnt_next, mcnt_inc;
    logic [10:0] period_next, period_diff;
    logic        h_fall, v_fall, period_match, fs_next, valid_next;
    logic [10:0] x_next;
    logic [8:0]  y_next;

    // hcnt_next/vline_next are the counter values belonging to the sample now in the synchronizer output.
    always_comb begin
        h_fall       = ~sync_bus[7] & h_prev_reg;
        v_fall       = ~sync_bus[6] & v_prev_reg;
        hcnt_next    = h_fall ? 11'd0 : (hcnt_reg == HCNT_MAX) ? HCNT_MAX : hcnt_reg + 11'd1;
        if (v_fall)
            vline_next = 10'd0;
        else if (h_fall && vline_reg != VLINE_MAX)
            vline_next = vline_reg + 10'd1;
        else
            vline_next = vline_reg;
        period_next  = (hcnt_reg == HCNT_MAX) ? HCNT_MAX : hcnt_reg + 11'd1;
        period_diff  = (period_next >= line_period) ? period_next - line_period
                                                    : line_period - period_next;
        period_match = (period_diff <= TOL);
        mcnt_inc     = mcnt_reg + 8'd1;

        state_next = state_reg;
        mcnt_next  = mcnt_reg;
        fs_next    = 1'b0;
        if (hcnt_next == HCNT_MAX) begin
            state_next = HUNT;
        end else begin
            case (state_reg)
                HUNT: if (h_fall) begin
                    state_next = HQUAL;
                    mcnt_next  = 8'd0;
                end
                HQUAL: if (h_fall) begin
                    if (period_match) begin
                        mcnt_next = mcnt_inc;
                        if (mcnt_inc == LOCK_N) state_next = VWAIT;
                    end else begin
                        mcnt_next = 8'd0;
                    end
                end
                VWAIT: if (v_fall) begin
                    state_next = LOCKED;
                    fs_next    = 1'b1;
                end
                LOCKED: begin
                    if (h_fall && !period_match) state_next = HUNT;
                    else if (v_fall)             fs_next    = 1'b1;
                end
                default: state_next = HUNT;
            endcase
        end

        valid_next = (state_next == LOCKED)
                   && ({1'b0, hcnt_next} >= H_LO) && ({1'b0, hcnt_next} < H_HI)
                   && ({1'b0, vline_next} >= V_LO) && ({1'b0, vline_next} < V_HI);
        x_next = hcnt_next - X_OFS;
        y_next = 9'(vline_next - Y_OFS);
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_reg       <= HUNT;
            h_prev_reg      <= 1'b1;
            v_prev_reg      <= 1'b1;
            hcnt_reg        <= '0;
            vline_reg       <= '0;
            mcnt_reg        <= '0;
            line_period     <= '0;
            frame_lines     <= '0;
            locked          <= 1'b0;
            pix.pix_valid   <= 1'b0;
            pix.pix_x       <= '0;
            pix.pix_y       <= '0;
            pix.pix_rgb     <= '0;
            pix.frame_start <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_prev_reg <= sync_bus[7];
            v_prev_reg <= sync_bus[6];
            hcnt_reg   <= hcnt_next;
            vline_reg  <= vline_next;
            mcnt_reg   <= mcnt_next;
            if (h_fall) line_period <= period_next;
            // The vsync that completes acquisition closes a partial frame, so its count is dropped.
            if (v_fall && state_reg != VWAIT) frame_lines <= vline_reg;
            locked          <= (state_next == LOCKED);
            pix.pix_valid   <= valid_next;
            pix.pix_x       <= valid_next ? x_next : 11'd0;
            pix.pix_y       <= valid_next ? y_next : 9'd0;
            pix.pix_rgb     <= valid_next ? sync_bus[5:0] : 6'd0;
            pix.frame_start <= fs_next;
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down VGA raster, with a timestamp-based
// reference model checked every cycle plus targeted lock/pixel scenarios.
`timescale 1ns/1ps
module tb_vga_capture;
    localparam int HAS = 12, HD = 40, VAS = 3, VD = 12, TOL = 2, LOCKN = 4;
    localparam int LEN = 60, HLOW = 8, NLINES = 20;
    localparam int S_HUNT = 0, S_HQUAL = 1, S_VWAIT = 2, S_LOCKED = 3;

    logic        clk48 = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1, vsync_in = 1'b1;
    logic [1:0]  r_in = 2'd0, g_in = 2'd0, b_in = 2'd0;
    logic        locked;
    logic [10:0] line_period;
    logic [9:0]  frame_lines;

    vga_capture_if vid ();

    vga_capture #(
        .H_ACTIVE_START(HAS), .H_DISPLAY(HD), .V_ACTIVE_START(VAS),
        .V_DISPLAY(VD), .H_TOL(TOL), .LOCK_LINES(LOCKN)
    ) dut (
        .clk48(clk48), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .pix(vid),
        .locked(locked), .line_period(line_period), .frame_lines(frame_lines)
    );

    always #5 clk48 = ~clk48;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [49:0] got_vec;
    assign got_vec = {vid.pix_valid, vid.pix_x, vid.pix_y, vid.pix_rgb, vid.frame_start,
                      locked, line_period, frame_lines};

    // Raster generator: hsync low for the first HLOW clocks of every line, vsync low for two lines starting voff clocks into line 0.
    int hpos = 0, lno = 0, cur_len = LEN, next_len = LEN, voff = 30;
    bit hold_h = 0, rand_rgb = 0;
    logic [5:0] rgb_drv;
    always @(negedge clk48) begin
        hsync_in = hold_h ? 1'b1 : (hpos >= HLOW);
        vsync_in = !((lno == 0 && hpos >= voff) || lno == 1 || (lno == 2 && hpos < voff));
        rgb_drv  = rand_rgb ? 6'($urandom) : {3{2'(hpos)}};
        {r_in, g_in, b_in} = rgb_drv;
        hpos++;
        if (hpos >= cur_len) begin
            hpos     = 0;
            lno      = (lno + 1) % NLINES;
            cur_len  = next_len;
            next_len = LEN;
        end
    end

    // Reference model: hcnt is the time since the last hsync fall, vline the hsync falls since the last vsync fall.
    bit [7:0]    m_s1, m_s2, cur;
    bit          m_hp, m_vp, hf, vf, match, fs, valid;
    longint      t = 0, hf_t = 0, period, hc, d;
    int          nl, lp, fl, mc, st;
    logic [49:0] exp_vec = '0;
    always @(posedge clk48) begin
        t++;
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_hp = 1; m_vp = 1; hf_t = t;
            nl = 0; lp = 0; fl = 0; mc = 0; st = S_HUNT; exp_vec = '0;
        end else begin
            cur  = m_s2;
            m_s2 = m_s1;
            m_s1 = {hsync_in, vsync_in, r_in, g_in, b_in};
            hf   = !cur[7] && m_hp;
            vf   = !cur[6] && m_vp;
            m_hp = cur[7];
            m_vp = cur[6];
            period = (t - hf_t > 2047) ? 2047 : t - hf_t;
            if (hf) hf_t = t;
            hc = (t - hf_t > 2047) ? 2047 : t - hf_t;
            d = period - lp;
            if (d < 0) d = -d;
            match = (d <= TOL);
            fs = 0;
            if (vf && st != S_VWAIT) fl = nl;
            if (vf) nl = 0;
            else if (hf && nl < 1023) nl++;
            if (hc == 2047) st = S_HUNT;
            else case (st)
                S_HUNT:  if (hf) begin st = S_HQUAL; mc = 0; end
                S_HQUAL: if (hf) begin
                    if (match) begin mc++; if (mc == LOCKN) st = S_VWAIT; end
                    else mc = 0;
                end
                S_VWAIT: if (vf) begin st = S_LOCKED; fs = 1; end
                default: if (hf && !match) st = S_HUNT; else if (vf) fs = 1;
            endcase
            if (hf) lp = int'(period);
            valid = (st == S_LOCKED) && hc >= HAS && hc < HAS + HD && nl >= VAS && nl < VAS + VD;
            exp_vec = {valid, valid ? 11'(hc - HAS) : 11'd0, valid ? 9'(nl - VAS) : 9'd0,
                       valid ? cur[5:0] : 6'd0, fs, st == S_LOCKED, 11'(lp), 10'(fl)};
        end
    end

    always @(negedge clk48) if (chk_en) chk("cycle", got_vec, exp_vec);

    task automatic wait_lock(input string tag, input logic want, input int budget);
        int n = 0;
        while (locked !== want && n < budget) begin @(negedge clk48); n++; end
        chk(tag, locked, want);
    endtask

    task automatic wait_fs(input int budget, output int cycles);
        cycles = 0;
        do begin @(negedge clk48); cycles++; end
        while (vid.frame_start !== 1'b1 && cycles < budget);
    endtask

    task automatic wait_lno(input int target);
        int n = 0;
        while (lno != target && n < 2 * NLINES * LEN) begin @(negedge clk48); n++; end
    endtask

    int row_cnt [0:511];
    int c, nvalid, rows, xmax, nfs, first, n;
    logic [10:0] fx;
    logic [8:0]  fy;
    logic [1:0]  ec;

    initial begin
        repeat (3) @(negedge clk48);
        chk_en = 1;
        chk("rst_out", got_vec, 50'd0);
        rst = 0;
        $display("reset released at %0t", $time);

        wait_lock("acq_lock", 1'b1, 6 * NLINES * LEN);
        chk("acq_fs", vid.frame_start, 1'b1);
        chk("acq_period", line_period, LEN);
        $display("acquire: locked at %0t line_period=%0d", $time, line_period);

        wait_fs(2 * NLINES * LEN, c);
        chk("fl_fs_seen", vid.frame_start, 1'b1);
        chk("frame_lines", frame_lines, NLINES);
        $display("frame: frame_lines=%0d", frame_lines);

        for (int r = 0; r < 512; r++) row_cnt[r] = 0;
        nvalid = 0; xmax = 0;
        for (int i = 0; i < NLINES * LEN - 1; i++) begin
            @(negedge clk48);
            if (vid.pix_valid) begin
                row_cnt[vid.pix_y]++;
                nvalid++;
                if (int'(vid.pix_x) > xmax) xmax = int'(vid.pix_x);
                ec = 2'(vid.pix_x + HAS);
                chk("rgb", vid.pix_rgb, {ec, ec, ec});
            end
        end
        rows = 0;
        for (int r = 0; r < 512; r++) if (row_cnt[r] != 0) rows++;
        chk("rows", rows, VD);
        chk("row0_px", row_cnt[0], HD);
        chk("rowlast_px", row_cnt[VD-1], HD);
        chk("valid_total", nvalid, HD * VD);
        chk("x_max", xmax, HD - 1);
        $display("pixels: %0d valid in %0d rows, x_max=%0d", nvalid, rows, xmax);

        rand_rgb = 1;
        repeat (NLINES * LEN) @(negedge clk48);
        rand_rgb = 0;
        $display("random colour frame done");

        for (int k = 0; k < 6; k++) begin
            wait_lno((lno + 2) % NLINES);
            next_len = ($urandom % 2) ? LEN - 1 : LEN + 2;
            $display("jitter: line length %0d", next_len);
            repeat (2 * LEN) @(negedge clk48);
            chk("jit_lock", locked, 1'b1);
        end

        wait_lno(10);
        next_len = LEN + 5;
        wait_lock("bad_drop", 1'b0, 4 * LEN);
        chk("bad_valid", vid.pix_valid, 1'b0);
        $display("bad line: lock dropped at %0t", $time);
        wait_lock("relock1", 1'b1, 4 * NLINES * LEN);

        hold_h = 1;
        n = 0;
        while (locked && n < 2300) begin @(negedge clk48); n++; end
        chk("hold_drop", locked, 1'b0);
        chk("hold_late", n >= 1900, 1'b1);
        $display("hsync hold: lock dropped after %0d cycles", n);
        hold_h = 0;
        wait_lock("relock2", 1'b1, 4 * NLINES * LEN);

        wait_lno(8);
        rst = 1;
        @(negedge clk48);
        rst = 0;
        chk("rst_mid", got_vec, 50'd0);
        wait_fs(4 * NLINES * LEN, c);
        chk("rst_fs_seen", vid.frame_start, 1'b1);
        chk("rst_fs_gap", c >= 4 * LEN, 1'b1);
        chk("rst_relock", locked, 1'b1);
        $display("mid-frame reset: next frame_start after %0d cycles", c);

        wait_lno(10);
        voff = 0;
        wait_fs(2 * NLINES * LEN, c);
        chk("co_fs_seen", vid.frame_start, 1'b1);
        nfs = 0; first = -1; fx = '1; fy = '1;
        for (int i = 0; i < NLINES * LEN - 5; i++) begin
            if (i > 0) @(negedge clk48);
            if (vid.frame_start) nfs++;
            if (vid.pix_valid && first < 0) begin first = i; fx = vid.pix_x; fy = vid.pix_y; end
        end
        chk("co_fs_count", nfs, 1);
        chk("co_first_px", first, VAS * LEN + HAS);
        chk("co_first_x", fx, 0);
        chk("co_first_y", fy, 0);
        chk("co_locked", locked, 1'b1);
        $display("coincident syncs: first pixel %0d cycles after frame_start", first);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE_START, default 274: hcnt value of the first active pixel, with hcnt=0 on the hsync-fall detect cycle.
REQ-002 SHALL have parameter H_DISPLAY, default 1220: active pixels per line.
REQ-003 SHALL have parameter V_ACTIVE_START, default 35: vline value of the first active line, with vline=0 on the vsync-fall detect cycle.
REQ-004 SHALL have parameter V_DISPLAY, default 480: active lines per frame.
REQ-005 SHALL have parameter H_TOL, default 2: allowed line-period jitter, in clocks.
REQ-006 SHALL have parameter LOCK_LINES, default 4: consecutive matching line periods needed to qualify horizontal timing.
REQ-007 SHALL have port clk48, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have ports hsync_in and vsync_in, input, 1 bit each: active-low syncs, asynchronous to clk48.
REQ-010 SHALL have ports r_in, g_in and b_in, input, 2 bits each: pixel colour.
REQ-011 SHALL have port pix_valid, output, 1 bit: pix_x, pix_y and pix_rgb hold an active pixel.
REQ-012 SHALL have port pix_x, output, 11 bits: active column, 0..H_DISPLAY-1.
REQ-013 SHALL have port pix_y, output, 9 bits: active row, 0..V_DISPLAY-1.
REQ-014 SHALL have port pix_rgb, output, 6 bits: {r,g,b}.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the vsync-fall detect cycle, LOCKED state only.
REQ-016 SHALL have port locked, output, 1 bit: high in LOCKED state.
REQ-017 SHALL have port line_period, output, 11 bits: last measured hsync-fall-to-hsync-fall distance.
REQ-018 SHALL have port frame_lines, output, 10 bits: lines counted in the last complete frame.

Function
REQ-019 SHALL pass hsync_in, vsync_in and the colour bits through a 2-flop synchronizer, all delayed equally.
REQ-020 SHALL detect each sync fall on the cycle the synchronized value is 0 and its previous value was 1.
REQ-021 SHALL keep an 11-bit hcnt: cleared on hsync fall, otherwise incremented, saturating at 2047.
REQ-022 SHALL keep a 10-bit vline: cleared on vsync fall, incremented on hsync fall, saturating at 1023.
REQ-023 SHALL clear vline to 0 when both syncs fall in the same cycle; vsync wins, and hcnt also clears.
REQ-024 SHALL, on each hsync fall, load line_period with hcnt+1 and compare it with the previous period; a match means |difference| <= H_TOL.
REQ-025 SHALL, on each vsync fall, load frame_lines with vline, except for the first vsync after entering VWAIT.
REQ-026 SHALL run a state machine with states HUNT, HQUAL, VWAIT and LOCKED.
REQ-027 HUNT SHALL go to HQUAL on the first hsync fall, with the match count cleared.
REQ-028 HQUAL SHALL increment the match count on each matching period and clear it on a mismatch; it SHALL go to VWAIT when the count reaches LOCK_LINES.
REQ-029 VWAIT SHALL go to LOCKED on the next vsync fall and pulse frame_start on that cycle.
REQ-030 LOCKED SHALL go to HUNT on any period mismatch; this raises no frame_start.
REQ-031 Any state SHALL go to HUNT when hcnt reaches 2047, the hsync loss timeout.
REQ-032 SHALL assert pix_valid only when locked, H_ACTIVE_START <= hcnt < H_ACTIVE_START+H_DISPLAY, and V_ACTIVE_START <= vline < V_ACTIVE_START+V_DISPLAY.
REQ-033 SHALL set pix_x = hcnt-H_ACTIVE_START and pix_y = vline-V_ACTIVE_START, each truncated to its port width.
REQ-034 SHALL register all outputs; total latency from pad to pix_rgb is 3 clk48 cycles (2 sync stages plus 1 output register).
REQ-035 SHALL make pix_x, pix_y and pix_rgb zero whenever pix_valid is 0.
REQ-036 SHALL drop locked and pix_valid in the same cycle as the transition that leaves LOCKED.

Reset
REQ-037 SHALL, on rst high at a clock edge, enter HUNT and zero hcnt, vline, the match count, line_period, frame_lines and every output, including the synchronizer flops, which reset to 1.
REQ-038 SHALL give rst priority over all events, including in the middle of a line or frame, with no frame_start on release.
REQ-039 SHALL restart acquisition from HUNT after rst is released.

Verification
REQ-040 Bench SHALL drive the vgademo timing (1525 clk/line, hsync low for 183 clk, 525 lines, vsync low for 2 lines) -> locked rises at the first vsync fall after 4 or more lines; line_period=1525; after one more full frame, frame_lines=525.
REQ-041 Bench SHALL, once locked, drive a line where r,g,b = h_count[1:0] -> pix_x runs 0..1219 with pix_rgb matching 3 cycles after the pad; exactly 1220 pix_valid cycles per line and 480 valid lines per frame.
REQ-042 Bench SHALL jitter the line length to 1524 or 1527 (within H_TOL) -> stays locked; a 1530-clk line -> HUNT and locked=0 in the same cycle.
REQ-043 Bench SHALL hold hsync_in high -> locked drops when hcnt reaches 2047; re-applying valid sync -> relock at the next qualifying vsync.
REQ-044 Bench SHALL assert rst for 1 cycle mid-frame while locked -> the next cycle has all outputs 0 and state HUNT; no frame_start until 4 or more lines and a vsync fall have followed.
REQ-045 Bench SHALL make the hsync and vsync falls coincide -> vline=0, hcnt=0, and a single frame_start pulse.
